// File: rtl/dictionary_rank_pkg.sv
// Shared types and constants for the permutation-to-rank converter.
// The multiplier table drives the Horner-style rank accumulation.
package dictionary_rank_pkg;

  localparam int N      = 8;
  localparam int ELEM_W = 3;
  localparam int RANK_W = 16;

  localparam logic [ELEM_W-1:0] LAST_IDX = ELEM_W'(N - 2);

  typedef enum logic [1:0] {
    state_idle,
    state_calc,
    state_done
  } state_t;

  typedef logic [N-1:0][ELEM_W-1:0] perm_t;

  // Radix for position i is (N - i): 8,7,6,5,4,3,2 over the visited positions.
  function automatic logic [RANK_W-1:0] multFor(input logic [ELEM_W-1:0] idx);
    logic [RANK_W-1:0] m;
    case (idx)
      3'd0:    m = 16'd8;
      3'd1:    m = 16'd7;
      3'd2:    m = 16'd6;
      3'd3:    m = 16'd5;
      3'd4:    m = 16'd4;
      3'd5:    m = 16'd3;
      3'd6:    m = 16'd2;
      default: m = 16'd1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dictionary_rank_if.sv
// Request/result bundle for dictionary_rank: start plus elements A..H in,
// rank/error/busy/finish out.
interface dictionary_rank_if;
  import dictionary_rank_pkg::*;

  logic              start;
  logic [ELEM_W-1:0] A;
  logic [ELEM_W-1:0] B;
  logic [ELEM_W-1:0] C;
  logic [ELEM_W-1:0] D;
  logic [ELEM_W-1:0] E;
  logic [ELEM_W-1:0] F;
  logic [ELEM_W-1:0] G;
  logic [ELEM_W-1:0] H;
  logic [RANK_W-1:0] rank;
  logic              error;
  logic              busy;
  logic              finish;

  modport master (
    output start, A, B, C, D, E, F, G, H,
    input  rank, error, busy, finish
  );

  modport slave (
    input  start, A, B, C, D, E, F, G, H,
    output rank, error, busy, finish
  );

endinterface

// File: rtl/dictionary_rank_smaller_count.sv
// Combinational: counts entries at positions after i whose value is below perm[i].
// Result is at most 7, so a 3-bit count never wraps.
module dictionary_rank_smaller_count
  import dictionary_rank_pkg::*;
(
  input  perm_t             i_perm,
  input  logic [ELEM_W-1:0] i_idx,
  output logic [ELEM_W-1:0] o_count
);

  logic [ELEM_W-1:0] w_pivot;
  logic [ELEM_W-1:0] w_acc;

  always_comb begin
    w_pivot = i_perm[i_idx];
    w_acc   = '0;
    for (int j = 0; j < N; j++) begin
      if ((j > int'(i_idx)) && (i_perm[3'(j)] < w_pivot)) begin
        w_acc = w_acc + 3'd1;
      end
    end
  end

  assign o_count = w_acc;

endmodule

// File: rtl/dictionary_rank.sv
// Lexicographic rank of an 8-element permutation, one position per clock.
// Duplicates are flagged immediately via an occupancy vector on the inputs.
module dictionary_rank
  import dictionary_rank_pkg::*;
(
  input logic               clk,
  input logic               reset,
  dictionary_rank_if.slave  bus
);

  state_t            r_state;
  state_t            w_stateNext;
  perm_t             r_perm;
  perm_t             w_permNext;
  logic [RANK_W-1:0] r_rank;
  logic [RANK_W-1:0] w_rankNext;
  logic              r_error;
  logic              w_errorNext;
  logic [ELEM_W-1:0] r_idx;
  logic [ELEM_W-1:0] w_idxNext;

  perm_t             w_inPerm;
  logic [N-1:0]      w_occ;
  logic              w_valid;
  logic [ELEM_W-1:0] w_count;
  logic [RANK_W-1:0] w_stepRank;

  assign w_inPerm[0] = bus.A;
  assign w_inPerm[1] = bus.B;
  assign w_inPerm[2] = bus.C;
  assign w_inPerm[3] = bus.D;
  assign w_inPerm[4] = bus.E;
  assign w_inPerm[5] = bus.F;
  assign w_inPerm[6] = bus.G;
  assign w_inPerm[7] = bus.H;

  // Eight values covering all eight slots implies no value repeats.
  always_comb begin
    w_occ = '0;
    for (int k = 0; k < N; k++) begin
      w_occ[w_inPerm[3'(k)]] = 1'b1;
    end
  end

  assign w_valid = &w_occ;

  dictionary_rank_smaller_count u_smallerCount (
    .i_perm  (r_perm),
    .i_idx   (r_idx),
    .o_count (w_count)
  );

  assign w_stepRank = (r_rank * multFor(r_idx)) + RANK_W'(w_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= state_idle;
      r_perm  <= '0;
      r_rank  <= '0;
      r_error <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_perm  <= w_permNext;
      r_rank  <= w_rankNext;
      r_error <= w_errorNext;
      r_idx   <= w_idxNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_permNext  = r_perm;
    w_rankNext  = r_rank;
    w_errorNext = r_error;
    w_idxNext   = r_idx;

    case (r_state)
      state_idle, state_done: begin
        if (bus.start) begin
          w_permNext = w_inPerm;
          w_rankNext = '0;
          w_idxNext  = '0;
          if (w_valid) begin
            w_stateNext = state_calc;
            w_errorNext = 1'b0;
          end else begin
            w_stateNext = state_done;
            w_errorNext = 1'b1;
          end
        end
      end
      state_calc: begin
        w_rankNext = w_stepRank;
        if (r_idx == LAST_IDX) begin
          w_stateNext = state_done;
        end else begin
          w_idxNext = r_idx + 3'd1;
        end
      end
      default: begin
        w_stateNext = state_idle;
      end
    endcase
  end

  assign bus.rank   = r_rank;
  assign bus.error  = r_error;
  assign bus.busy   = (r_state == state_calc);
  assign bus.finish = (r_state == state_done);

endmodule

// File: tb/tb_dictionary_rank.sv
// Scoreboard bench for dictionary_rank: expected results are queued at start
// and popped when finish rises; includes a generator round-trip.
module tb_dictionary_rank;
  import dictionary_rank_pkg::*;

  typedef struct packed {
    logic [15:0] rank;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  dictionary_rank_if bus ();

  dictionary_rank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Permutations are written as 8 octal digits, A first.
  function automatic exp_t modelRank(input bit [23:0] v);
    int   p[8];
    bit [7:0] seen;
    int   r;
    int   c;
    int   fact;
    exp_t e;
    seen = '0;
    e.rank = '0;
    e.err  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p[i] = int'(v[23-3*i -: 3]);
      seen[p[i]] = 1'b1;
    end
    if (seen != 8'hFF) begin
      e.err = 1'b1;
      return e;
    end
    r = 0;
    for (int i = 0; i < 8; i++) begin
      c = 0;
      for (int j = i + 1; j < 8; j++) if (p[j] < p[i]) c++;
      fact = 1;
      for (int k = 2; k <= 7 - i; k++) fact = fact * k;
      r = r + c * fact;
    end
    e.rank = 16'(r);
    return e;
  endfunction

  function automatic bit [23:0] nextPerm(input bit [23:0] v);
    int a[8];
    int i;
    int j;
    int t;
    bit [23:0] o;
    for (int k = 0; k < 8; k++) a[k] = int'(v[23-3*k -: 3]);
    i = 6;
    while (i >= 0 && a[i] >= a[i+1]) i--;
    if (i < 0) return 24'o01234567;
    j = 7;
    while (a[j] <= a[i]) j--;
    t = a[i]; a[i] = a[j]; a[j] = t;
    for (int lo = i + 1, hi = 7; lo < hi; lo++, hi--) begin
      t = a[lo]; a[lo] = a[hi]; a[hi] = t;
    end
    o = '0;
    for (int k = 0; k < 8; k++) o[23-3*k -: 3] = 3'(a[k]);
    return o;
  endfunction

  function automatic bit [23:0] shufflePerm();
    int a[8];
    int j;
    int t;
    bit [23:0] o;
    for (int k = 0; k < 8; k++) a[k] = k;
    for (int k = 7; k > 0; k--) begin
      j = int'($urandom_range(k, 0));
      t = a[k]; a[k] = a[j]; a[j] = t;
    end
    o = '0;
    for (int k = 0; k < 8; k++) o[23-3*k -: 3] = 3'(a[k]);
    return o;
  endfunction

  task automatic driveInputs(input bit [23:0] v);
    {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G, bus.H} = v;
  endtask

  task automatic applyStimulus(input bit [23:0] v, input exp_t expected, input bit push);
    @(negedge clk);
    driveInputs(v);
    bus.start = 1'b1;
    if (push) sbq.push_back(expected);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Called just after the sampling edge; that edge counts as edge 1.
  task automatic waitFinish(output int edges, output int busyCnt, output bit ok);
    edges = 1;
    busyCnt = 0;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.finish) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busyCnt++;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic popExpected(output exp_t e, output bit have);
    have = (sbq.size() > 0);
    e = '0;
    if (have) e = sbq.pop_front();
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    driveInputs(24'o01234567);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rank !== 16'd0 || bus.error !== 1'b0 || bus.busy !== 1'b0 || bus.finish !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got rank=%0d err=%b busy=%b fin=%b expected all zero",
               bus.rank, bus.error, bus.busy, bus.finish);
    end
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.finish !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got busy=%b fin=%b expected 0 0", bus.busy, bus.finish);
    end
  endtask

  task automatic test_known();
    bit [23:0] vecs[5] = '{24'o01234567, 24'o76543210, 24'o01234576, 24'o10234567, 24'o31402756};
    int        ranks[5] = '{0, 40319, 1, 5040, 16084};
    int        edges;
    int        busyCnt;
    bit        ok;
    bit        have;
    exp_t      e;
    for (int t = 0; t < 5; t++) begin
      applyStimulus(vecs[t], exp_t'{rank: 16'(ranks[t]), err: 1'b0}, 1'b1);
      waitFinish(edges, busyCnt, ok);
      popExpected(e, have);
      checks++;
      if (!ok || !have) begin
        errors++;
        $display("[TB] FAIL known_timeout vec %o finished=%b queued=%b expected 1 1", vecs[t], ok, have);
        continue;
      end
      checks++;
      if (bus.rank !== e.rank || bus.error !== e.err) begin
        errors++;
        $display("[TB] FAIL known_rank vec %o got %0d/%b expected %0d/%b",
                 vecs[t], bus.rank, bus.error, e.rank, e.err);
      end
      checks++;
      if (edges != 8 || busyCnt != 7) begin
        errors++;
        $display("[TB] FAIL known_latency vec %o got edges=%0d busy=%0d expected 8 7", vecs[t], edges, busyCnt);
      end
    end
  endtask

  task automatic test_duplicate();
    int   edges;
    int   busyCnt;
    bit   ok;
    bit   have;
    exp_t e;
    applyStimulus(24'o01234566, modelRank(24'o01234566), 1'b1);
    waitFinish(edges, busyCnt, ok);
    popExpected(e, have);
    checks++;
    if (!ok || !have || bus.rank !== e.rank || bus.error !== e.err || edges != 1 || busyCnt != 0) begin
      errors++;
      $display("[TB] FAIL duplicate got fin=%b rank=%0d err=%b edges=%0d busy=%0d expected 1 %0d %b 1 0",
               ok, bus.rank, bus.error, edges, busyCnt, e.rank, e.err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.finish !== 1'b1 || bus.error !== 1'b1 || bus.rank !== 16'd0) begin
      errors++;
      $display("[TB] FAIL duplicate_hold got fin=%b err=%b rank=%0d expected 1 1 0",
               bus.finish, bus.error, bus.rank);
    end
  endtask

  task automatic test_ignore_start();
    int   edges;
    int   busyCnt;
    bit   ok;
    bit   have;
    exp_t e;
    applyStimulus(24'o31402756, modelRank(24'o31402756), 1'b1);
    @(negedge clk);
    driveInputs(24'o76543210);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitFinish(edges, busyCnt, ok);
    popExpected(e, have);
    checks++;
    if (!ok || !have || bus.rank !== e.rank || bus.error !== e.err || edges != 7) begin
      errors++;
      $display("[TB] FAIL ignore_start got fin=%b rank=%0d err=%b edges=%0d expected 1 %0d %b 7",
               ok, bus.rank, bus.error, edges, e.rank, e.err);
    end
  endtask

  task automatic test_reset_mid_calc();
    int   edges;
    int   busyCnt;
    bit   ok;
    bit   have;
    exp_t e;
    applyStimulus(24'o76543210, modelRank(24'o76543210), 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_abort_busy got %b expected 1", bus.busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rank !== 16'd0 || bus.error !== 1'b0 || bus.busy !== 1'b0 || bus.finish !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state got rank=%0d err=%b busy=%b fin=%b expected all zero",
               bus.rank, bus.error, bus.busy, bus.finish);
    end
    applyStimulus(24'o10234567, modelRank(24'o10234567), 1'b1);
    waitFinish(edges, busyCnt, ok);
    popExpected(e, have);
    checks++;
    if (!ok || !have || bus.rank !== e.rank || bus.error !== e.err || edges != 8) begin
      errors++;
      $display("[TB] FAIL after_abort got fin=%b rank=%0d err=%b edges=%0d expected 1 %0d %b 8",
               ok, bus.rank, bus.error, edges, e.rank, e.err);
    end
  endtask

  task automatic test_back_to_back();
    bit [23:0] p2;
    int        edges;
    int        busyCnt;
    bit        ok;
    bit        have;
    exp_t      e;
    p2 = shufflePerm();
    @(negedge clk);
    driveInputs(24'o01234576);
    bus.start = 1'b1;
    sbq.push_back(modelRank(24'o01234576));
    @(posedge clk);
    #1 driveInputs(p2);
    sbq.push_back(modelRank(p2));
    waitFinish(edges, busyCnt, ok);
    popExpected(e, have);
    checks++;
    if (!ok || !have || bus.rank !== e.rank || bus.error !== e.err || edges != 8) begin
      errors++;
      $display("[TB] FAIL b2b_first got fin=%b rank=%0d err=%b edges=%0d expected 1 %0d %b 8",
               ok, bus.rank, bus.error, edges, e.rank, e.err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.finish !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_restart got fin=%b busy=%b expected 0 1", bus.finish, bus.busy);
    end
    waitFinish(edges, busyCnt, ok);
    bus.start = 1'b0;
    popExpected(e, have);
    checks++;
    if (!ok || !have || bus.rank !== e.rank || bus.error !== e.err || edges != 8) begin
      errors++;
      $display("[TB] FAIL b2b_second perm %o got fin=%b rank=%0d err=%b edges=%0d expected 1 %0d %b 8",
               p2, ok, bus.rank, bus.error, edges, e.rank, e.err);
    end
  endtask

  task automatic test_round_trip();
    bit [23:0] v;
    int        edges;
    int        busyCnt;
    bit        ok;
    bit        have;
    exp_t      e;
    v = 24'o01234567;
    for (int k = 0; k < 200; k++) begin
      applyStimulus(v, exp_t'{rank: 16'(k), err: 1'b0}, 1'b1);
      waitFinish(edges, busyCnt, ok);
      popExpected(e, have);
      checks++;
      if (!ok || !have || bus.rank !== e.rank || bus.error !== e.err) begin
        errors++;
        $display("[TB] FAIL round_trip step %0d perm %o got rank=%0d err=%b expected %0d %b",
                 k, v, bus.rank, bus.error, e.rank, e.err);
      end
      v = nextPerm(v);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    driveInputs(24'o0);
    test_reset();
    test_known();
    test_duplicate();
    test_ignore_start();
    test_reset_mid_calc();
    test_back_to_back();
    test_round_trip();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover got %0d entries expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
